// File: rtl/seqchk_pkg.sv
// Shared types and default code tables for the token sequence checker.
package seqchk_pkg;

    typedef enum logic [1:0] {
        RES_NONE  = 2'b00,
        RES_ACC_A = 2'b01,
        RES_ACC_B = 2'b10,
        RES_REJ   = 2'b11
    } result_e;

    typedef enum logic [1:0] {
        RSN_ORDER   = 2'b00,
        RSN_ABORT   = 2'b01,
        RSN_OVERLEN = 2'b10,
        RSN_UNKNOWN = 2'b11
    } reason_e;

    localparam int DEF_SYM_W   = 7;
    localparam int DEF_N_TOK   = 5;
    localparam int DEF_MAX_LEN = 16;

    // Token i+1 lives at [i*SYM_W +: SYM_W]; token 1 is the rightmost entry.
    localparam logic [DEF_N_TOK*DEF_SYM_W-1:0] DEF_TOK_CODES =
        {7'h0C, 7'h28, 7'h4F, 7'h6B, 7'h58};
    localparam logic [DEF_N_TOK*(DEF_N_TOK+1)-1:0] DEF_PRED_MASK =
        30'b010001_101001_010101_001011_000101;

    localparam logic [DEF_SYM_W-1:0] DEF_TERM_A_CODE = 7'h32;
    localparam logic [DEF_N_TOK:0]   DEF_TERM_A_MASK = 6'b001110;
    localparam logic [DEF_SYM_W-1:0] DEF_TERM_B_CODE = 7'h23;
    localparam logic [DEF_N_TOK:0]   DEF_TERM_B_MASK = 6'b110000;
    localparam logic [DEF_SYM_W-1:0] DEF_ABORT_CODE  = 7'h16;

endpackage

// File: rtl/seqchk_classify.sv
// Combinational symbol decoder: abort, terminators and ordinary tokens,
// with abort > terminator A > terminator B > token precedence.
module seqchk_classify
    import seqchk_pkg::*;
#(
    parameter int                     SYM_W       = DEF_SYM_W,
    parameter int                     N_TOK       = DEF_N_TOK,
    parameter int                     IDX_W       = $clog2(DEF_N_TOK + 1),
    parameter logic [N_TOK*SYM_W-1:0] TOK_CODES   = DEF_TOK_CODES,
    parameter logic [SYM_W-1:0]       TERM_A_CODE = DEF_TERM_A_CODE,
    parameter logic [SYM_W-1:0]       TERM_B_CODE = DEF_TERM_B_CODE,
    parameter logic [SYM_W-1:0]       ABORT_CODE  = DEF_ABORT_CODE
) (
    input  logic [SYM_W-1:0] sym_data,
    output logic             is_abort,
    output logic             is_term_a,
    output logic             is_term_b,
    output logic             is_tok,
    output logic [IDX_W-1:0] tok_idx
);

    logic [N_TOK-1:0] tok_hit;

    genvar gi;
    generate
        for (gi = 0; gi < N_TOK; gi++) begin : g_tok_cmp
            assign tok_hit[gi] = (sym_data == TOK_CODES[gi*SYM_W +: SYM_W]);
        end
    endgenerate

    assign is_abort  = (sym_data == ABORT_CODE);
    assign is_term_a = (sym_data == TERM_A_CODE) && !is_abort;
    assign is_term_b = (sym_data == TERM_B_CODE) && !is_abort && !is_term_a;
    assign is_tok    = (|tok_hit) && !is_abort && !is_term_a && !is_term_b;

    // Scan downward so the lowest matching index is the one left standing.
    always_comb begin
        tok_idx = '0;
        for (int i = N_TOK - 1; i >= 0; i--) begin
            if (tok_hit[i]) tok_idx = IDX_W'(i + 1);
        end
    end

endmodule

// File: rtl/token_sequence_checker.sv
// Clocked token-order checker: tracks the last accepted token class and
// latches an accept/reject verdict until reset or restart.
module token_sequence_checker
    import seqchk_pkg::*;
#(
    parameter int                           SYM_W       = DEF_SYM_W,
    parameter int                           N_TOK       = DEF_N_TOK,
    parameter logic [N_TOK*SYM_W-1:0]       TOK_CODES   = DEF_TOK_CODES,
    parameter logic [N_TOK*(N_TOK+1)-1:0]   PRED_MASK   = DEF_PRED_MASK,
    parameter logic [SYM_W-1:0]             TERM_A_CODE = DEF_TERM_A_CODE,
    parameter logic [N_TOK:0]               TERM_A_MASK = DEF_TERM_A_MASK,
    parameter logic [SYM_W-1:0]             TERM_B_CODE = DEF_TERM_B_CODE,
    parameter logic [N_TOK:0]               TERM_B_MASK = DEF_TERM_B_MASK,
    parameter logic [SYM_W-1:0]             ABORT_CODE  = DEF_ABORT_CODE,
    parameter int                           MAX_LEN     = DEF_MAX_LEN,
    parameter bit                           STRICT      = 1'b0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             restart,
    input  logic                             sym_valid,
    input  logic [SYM_W-1:0]                 sym_data,
    output logic                             sym_ready,
    output logic [$clog2(N_TOK+1)-1:0]       state,
    output logic [$clog2(MAX_LEN+1)-1:0]     len,
    output logic                             done,
    output logic [1:0]                       result,
    output logic [1:0]                       reason
);

    localparam int ST_W  = $clog2(N_TOK + 1);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic              is_abort, is_term_a, is_term_b, is_tok;
    logic [ST_W-1:0]   tok_idx;
    logic [N_TOK:0]    pred_row;

    logic [ST_W-1:0]   state_reg, state_next;
    logic [LEN_W-1:0]  len_reg, len_next;
    logic              done_reg, done_next;
    result_e           result_reg, result_next;
    reason_e           reason_reg, reason_next;

    seqchk_classify #(
        .SYM_W       (SYM_W),
        .N_TOK       (N_TOK),
        .IDX_W       (ST_W),
        .TOK_CODES   (TOK_CODES),
        .TERM_A_CODE (TERM_A_CODE),
        .TERM_B_CODE (TERM_B_CODE),
        .ABORT_CODE  (ABORT_CODE)
    ) u_classify (
        .sym_data  (sym_data),
        .is_abort  (is_abort),
        .is_term_a (is_term_a),
        .is_term_b (is_term_b),
        .is_tok    (is_tok),
        .tok_idx   (tok_idx)
    );

    // Allowed-predecessor row of the decoded token; only meaningful when is_tok.
    always_comb begin
        pred_row = '0;
        if (is_tok) pred_row = PRED_MASK[(int'(tok_idx) - 1)*(N_TOK+1) +: (N_TOK+1)];
    end

    always_comb begin
        state_next  = state_reg;
        len_next    = len_reg;
        done_next   = done_reg;
        result_next = result_reg;
        reason_next = reason_reg;
        if (sym_valid && !done_reg) begin
            if (is_abort) begin
                done_next   = 1'b1;
                result_next = RES_REJ;
                reason_next = RSN_ABORT;
            end else if (is_term_a) begin
                if (TERM_A_MASK[state_reg]) begin
                    done_next   = 1'b1;
                    result_next = RES_ACC_A;
                end
            end else if (is_term_b) begin
                if (TERM_B_MASK[state_reg]) begin
                    done_next   = 1'b1;
                    result_next = RES_ACC_B;
                end
            end else if (is_tok) begin
                // An illegal order outranks an overlength condition.
                if (!pred_row[state_reg]) begin
                    done_next   = 1'b1;
                    result_next = RES_REJ;
                    reason_next = RSN_ORDER;
                end else if (len_reg >= LEN_W'(MAX_LEN)) begin
                    done_next   = 1'b1;
                    result_next = RES_REJ;
                    reason_next = RSN_OVERLEN;
                end else begin
                    state_next = tok_idx;
                    len_next   = len_reg + LEN_W'(1);
                end
            end else if (STRICT) begin
                done_next   = 1'b1;
                result_next = RES_REJ;
                reason_next = RSN_UNKNOWN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            state_reg  <= '0;
            len_reg    <= '0;
            done_reg   <= 1'b0;
            result_reg <= RES_NONE;
            reason_reg <= RSN_ORDER;
        end else begin
            state_reg  <= state_next;
            len_reg    <= len_next;
            done_reg   <= done_next;
            result_reg <= result_next;
            reason_reg <= reason_next;
        end
    end

    assign state     = state_reg;
    assign len       = len_reg;
    assign done      = done_reg;
    assign result    = result_reg;
    assign reason    = reason_reg;
    assign sym_ready = ~done_reg;

endmodule

// File: tb/tb_token_sequence_checker.sv
// Scoreboard bench: two checker instances (default, and MAX_LEN=4 with STRICT=1)
// share one stimulus stream; a reference model queues expected outputs per cycle.
module tb_token_sequence_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       restart = 1'b0;
    logic       sym_valid = 1'b0;
    logic [6:0] sym_data = '0;

    logic       ready_a, done_a, ready_b, done_b;
    logic [2:0] state_a, state_b;
    logic [4:0] len_a;
    logic [2:0] len_b;
    logic [1:0] result_a, reason_a, result_b, reason_b;

    always #5 clk = ~clk;

    token_sequence_checker dut_a (
        .clk(clk), .reset(reset), .restart(restart),
        .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(ready_a),
        .state(state_a), .len(len_a), .done(done_a),
        .result(result_a), .reason(reason_a)
    );

    token_sequence_checker #(.MAX_LEN(4), .STRICT(1'b1)) dut_b (
        .clk(clk), .reset(reset), .restart(restart),
        .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(ready_b),
        .state(state_b), .len(len_b), .done(done_b),
        .result(result_b), .reason(reason_b)
    );

    // Reference model: last token, count, verdict.
    typedef struct {
        int st;
        int ln;
        bit dn;
        int res;
        int rsn;
    } mdl_t;

    mdl_t ma, mb;
    logic [13:0] qa[$];
    logic [13:0] qb[$];
    int total = 0;
    int bad = 0;
    int txn = 0;

    function automatic int tok_of(logic [6:0] d);
        int codes[5] = '{'h58, 'h6B, 'h4F, 'h28, 'h0C};
        for (int i = 0; i < 5; i++) if (int'(d) == codes[i]) return i + 1;
        return 0;
    endfunction

    // Which previous classes may precede token k.
    function automatic bit legal(int k, int p);
        case (k)
            1: return p == 0 || p == 2;
            2: return p == 0 || p == 1 || p == 3;
            3: return p == 0 || p == 2 || p == 4;
            4: return p == 0 || p == 3 || p == 5;
            5: return p == 0 || p == 4;
            default: return 0;
        endcase
    endfunction

    function automatic mdl_t step(mdl_t m, bit rst, bit rs, bit v, logic [6:0] d,
                                  int max_len, bit strict);
        mdl_t n = m;
        int k;
        if (rst || rs) begin
            n.st = 0; n.ln = 0; n.dn = 0; n.res = 0; n.rsn = 0;
            return n;
        end
        if (!v || m.dn) return n;
        k = tok_of(d);
        if (d == 7'h16) begin
            n.dn = 1; n.res = 3; n.rsn = 1;
        end else if (d == 7'h32) begin
            if (m.st >= 1 && m.st <= 3) begin n.dn = 1; n.res = 1; end
        end else if (d == 7'h23) begin
            if (m.st == 4 || m.st == 5) begin n.dn = 1; n.res = 2; end
        end else if (k != 0) begin
            if (!legal(k, m.st)) begin
                n.dn = 1; n.res = 3; n.rsn = 0;
            end else if (m.ln == max_len) begin
                n.dn = 1; n.res = 3; n.rsn = 2;
            end else begin
                n.st = k; n.ln = m.ln + 1;
            end
        end else if (strict) begin
            n.dn = 1; n.res = 3; n.rsn = 3;
        end
        return n;
    endfunction

    function automatic logic [13:0] pk(mdl_t m);
        return {3'(m.st), 5'(m.ln), m.dn, 2'(m.res), 2'(m.rsn), ~m.dn};
    endfunction

    task automatic issue(bit rst, bit rs, bit v, logic [6:0] d);
        @(negedge clk);
        reset = rst; restart = rs; sym_valid = v; sym_data = d;
        ma = step(ma, rst, rs, v, d, 16, 1'b0);
        mb = step(mb, rst, rs, v, d, 4, 1'b1);
        qa.push_back(pk(ma));
        qb.push_back(pk(mb));
        txn++;
        $display("txn %0d rst=%0b restart=%0b valid=%0b data=%02h expA=%h expB=%h",
                 txn, rst, rs, v, d, pk(ma), pk(mb));
    endtask

    task automatic sym(logic [6:0] d);
        issue(1'b0, 1'b0, 1'b1, d);
    endtask

    task automatic rs();
        issue(1'b0, 1'b1, 1'b0, 7'h00);
    endtask

    // Monitor: the registered outputs update every cycle, so each edge presents one result.
    always @(posedge clk) begin
        logic [13:0] exp_v, act_v;
        #1;
        if (qa.size() > 0) begin
            exp_v = qa.pop_front();
            act_v = {state_a, len_a, done_a, result_a, reason_a, ready_a};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL dut_a outputs act=%h exp=%h (state,len,done,result,reason,ready)",
                         act_v, exp_v);
            end
        end
        if (qb.size() > 0) begin
            exp_v = qb.pop_front();
            act_v = {state_b, 2'b00, len_b, done_b, result_b, reason_b, ready_b};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL dut_b outputs act=%h exp=%h (state,len,done,result,reason,ready)",
                         act_v, exp_v);
            end
        end
    end

    initial begin
        int r, sel, waited;
        logic [6:0] d;
        int pool[5] = '{'h58, 'h6B, 'h4F, 'h28, 'h0C};

        ma = '{0, 0, 0, 0, 0};
        mb = '{0, 0, 0, 0, 0};
        issue(1'b1, 1'b0, 1'b0, 7'h00);
        issue(1'b1, 1'b0, 1'b1, 7'h58);
        issue(1'b0, 1'b0, 1'b0, 7'h00);

        // accept A after 1,2,3
        sym(7'h58); sym(7'h6B); sym(7'h4F); sym(7'h32); sym(7'h58); rs();
        // accept B after 4,5; terminator A from state 4 is ignored
        sym(7'h28); sym(7'h0C); sym(7'h23); rs();
        sym(7'h28); sym(7'h32); sym(7'h23); rs();
        // bad order, then dropped symbol
        sym(7'h58); sym(7'h4F); sym(7'h58); sym(7'h16); rs();
        // abort idle and mid-sequence
        sym(7'h16); rs();
        sym(7'h58); sym(7'h6B); sym(7'h16); rs();
        // length limit on both instances (4 and 16)
        for (int i = 0; i < 17; i++) sym((i % 2 == 0) ? 7'h58 : 7'h6B);
        issue(1'b0, 1'b1, 1'b1, 7'h58);
        sym(7'h58);
        issue(1'b0, 1'b1, 1'b1, 7'h6B);
        // unknown symbol: strict rejects, default ignores
        sym(7'h7F); sym(7'h58); rs();
        // reset mid-sequence, reset beats restart
        sym(7'h58); sym(7'h6B);
        issue(1'b1, 1'b1, 1'b1, 7'h4F);
        issue(1'b0, 1'b0, 1'b1, 7'h4F);
        rs();

        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            sel = $urandom_range(0, 99);
            if (sel < 70)      d = 7'(pool[$urandom_range(0, 4)]);
            else if (sel < 79) d = 7'h32;
            else if (sel < 88) d = 7'h23;
            else if (sel < 91) d = 7'h16;
            else               d = 7'($urandom_range(0, 127));
            if (r < 1)
                issue(1'b1, 1'b0, 1'($urandom_range(0, 1)), d);
            else if (r < 4 || (ma.dn && mb.dn && r < 35))
                issue(1'b0, 1'b1, 1'($urandom_range(0, 1)), d);
            else
                issue(1'b0, 1'b0, r < 88, d);
        end
        issue(1'b0, 1'b0, 1'b0, 7'h00);

        waited = 0;
        while ((qa.size() > 0 || qb.size() > 0) && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (qa.size() > 0 || qb.size() > 0) begin
            bad++;
            total++;
            $display("FAIL drain pending act=%0d exp=0", qa.size() + qb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
